// File: rtl/spike_vote_decoder.sv
// ============================================================================
// Module   : spike_vote_decoder
// Purpose  : Windowed pos/neg spike vote per class, argmax scan, valid/ack result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spike_vote_decoder #(
  parameter int NUM_CLASSES = 10,
  parameter int WINDOW      = 64,
  parameter int COUNT_W     = 8,
  parameter int CLASS_W     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_CLASSES-1:0]    pos_spikes,
  input  logic [NUM_CLASSES-1:0]    neg_spikes,
  input  logic                      ack,
  output logic                      busy,
  output logic                      valid,
  output logic [CLASS_W-1:0]        class_out,
  output logic signed [COUNT_W-1:0] score_out
);

  localparam int c_WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [c_WIN_W-1:0] c_WIN_LAST  = c_WIN_W'(WINDOW - 1);
  localparam logic [CLASS_W-1:0] c_SCAN_LAST = CLASS_W'(NUM_CLASSES - 1);
  localparam logic signed [COUNT_W-1:0] c_SMAX = {1'b0, {(COUNT_W-1){1'b1}}};
  localparam logic signed [COUNT_W-1:0] c_SMIN = {1'b1, {(COUNT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_ARGMAX = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [c_WIN_W-1:0]          r_win_cnt;
  logic [CLASS_W-1:0]          r_scan_idx;
  logic signed [COUNT_W-1:0]   r_score [NUM_CLASSES];
  logic [CLASS_W-1:0]          r_best_idx;
  logic signed [COUNT_W-1:0]   r_best_score;
  logic [CLASS_W-1:0]          r_class_out;
  logic signed [COUNT_W-1:0]   r_score_out;

  logic                        w_start_win;
  logic signed [COUNT_W-1:0]   w_cur_score;
  logic                        w_take;
  logic [CLASS_W-1:0]          w_best_idx;
  logic signed [COUNT_W-1:0]   w_best_score;

  assign w_start_win = (r_state == S_IDLE) && start;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_ACCUM;
      S_ACCUM:  if (r_win_cnt == c_WIN_LAST) w_state_nxt = S_ARGMAX;
      S_ARGMAX: if (r_scan_idx == c_SCAN_LAST) w_state_nxt = S_DONE;
      S_DONE:   if (ack) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win_cnt  <= '0;
      r_scan_idx <= '0;
    end else if (w_start_win) begin
      r_win_cnt  <= '0;
      r_scan_idx <= '0;
    end else if (r_state == S_ACCUM) begin
      r_win_cnt  <= r_win_cnt + c_WIN_W'(1);
      r_scan_idx <= '0;
    end else if (r_state == S_ARGMAX) begin
      r_scan_idx <= r_scan_idx + CLASS_W'(1);
    end
  end

  // ---------------------------------------------------------------- per-class saturating scores
  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_class
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_score[gi] <= '0;
      end else if (w_start_win) begin
        r_score[gi] <= '0;
      end else if (r_state == S_ACCUM) begin
        // Coincident pos and neg spikes cancel.
        if (pos_spikes[gi] && !neg_spikes[gi] && (r_score[gi] != c_SMAX)) begin
          r_score[gi] <= r_score[gi] + COUNT_W'(1);
        end else if (neg_spikes[gi] && !pos_spikes[gi] && (r_score[gi] != c_SMIN)) begin
          r_score[gi] <= r_score[gi] - COUNT_W'(1);
        end
      end
    end
  end : g_class

  // ---------------------------------------------------------------- argmax scan
  assign w_cur_score  = r_score[r_scan_idx];
  // Strictly-greater replaces, so ties keep the lowest index.
  assign w_take       = (r_scan_idx == '0) || (w_cur_score > r_best_score);
  assign w_best_idx   = w_take ? r_scan_idx  : r_best_idx;
  assign w_best_score = w_take ? w_cur_score : r_best_score;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_best_idx   <= '0;
      r_best_score <= '0;
      r_class_out  <= '0;
      r_score_out  <= '0;
    end else if (r_state == S_ARGMAX) begin
      r_best_idx   <= w_best_idx;
      r_best_score <= w_best_score;
      if (r_scan_idx == c_SCAN_LAST) begin
        r_class_out <= w_best_idx;
        r_score_out <= w_best_score;
      end
    end
  end

  assign busy      = (r_state == S_ACCUM) || (r_state == S_ARGMAX);
  assign valid     = (r_state == S_DONE);
  assign class_out = r_class_out;
  assign score_out = r_score_out;

endmodule

`default_nettype wire
